// File: rtl/equiv_check_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// equiv_pkg
//   Shared definitions for the equivalence-check sequencer:
//   - state_t    : FSM state encoding (IDLE, SETTLE, CHECK, DONE)
//   - NVEC       : number of vectors for the default input width
//   - range limits for N_IN and SETTLE_CYC
//   - nvec_of()  : number of vectors for a given input width
// -----------------------------------------------------------------------------
package equiv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int N_IN_DEFAULT = 2;
   localparam int NVEC         = 1 << N_IN_DEFAULT;

   localparam int N_IN_MIN     = 1;
   localparam int N_IN_MAX     = 8;
   localparam int SETTLE_MIN   = 0;
   localparam int SETTLE_MAX   = 15;

   function automatic int nvec_of(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/equiv_check_sequencer_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   4-bit load/decrement counter. Loading takes priority; otherwise the count
//   decrements until it reaches zero and then rests there.
// Ports
//   clk     in  1  rising-edge clock
//   reset   in  1  asynchronous active-high reset (count -> 0)
//   load    in  1  load val into the counter at the next edge
//   val     in  4  value to load
//   expired out 1  count is zero
// -----------------------------------------------------------------------------
module settle_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] val,
   output logic       expired
);

   logic [3:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 4'd0;
      end else if (load) begin
         count <= val;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign expired = (count == 4'd0);

endmodule

// File: rtl/equiv_check_sequencer.sv
// -----------------------------------------------------------------------------
// equiv_check_sequencer
//   Sweeps every input vector 0..2^N_IN-1 onto two implementations of the same
//   function, waits SETTLE_CYC cycles per vector, then compares res_a/res_b.
//   Reports mismatch count, lowest failing vector and pass/fail.
//
// Handshake: start/abort are levels. start is only looked at in IDLE or DONE;
//   abort cancels a running sweep and, in IDLE/DONE, overrides start.
//
// Parameters
//   N_IN        number of function inputs (1..8)
//   SETTLE_CYC  wait cycles between driving x_out and sampling results (0..15)
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start, abort      sweep control levels
//   res_a, res_b      outputs of the two implementations
//   x_out             vector driven to both implementations
//   busy              SETTLE or CHECK
//   done              DONE state; held until next start or reset
//   pass              done with zero mismatches
//   mismatch_cnt      mismatching vectors in the last sweep
//   first_fail_vec    lowest mismatching vector
//   first_fail_valid  first_fail_vec is meaningful
//   fsm_state         current FSM state (debug)
// -----------------------------------------------------------------------------
module equiv_check_sequencer
   import equiv_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int SETTLE_CYC = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            res_a,
   input  logic            res_b,
   output logic [N_IN-1:0] x_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid,
   output state_t          fsm_state
);

   localparam int              NV         = nvec_of(N_IN);
   localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(NV - 1);
   // SETTLE occupies exactly SETTLE_CYC cycles, so the timer is loaded with
   // one less; with SETTLE_CYC==0 SETTLE is skipped entirely.
   localparam logic [3:0]      LOAD_VAL   = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
   localparam state_t          AFTER_LOAD = (SETTLE_CYC == 0) ? CHECK : SETTLE;

   state_t state, state_n;
   logic   start_sweep;
   logic   check_en;
   logic   timer_load;
   logic   expired;
   logic   mismatch;

   settle_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (timer_load),
      .val     (LOAD_VAL),
      .expired (expired)
   );

   assign mismatch = res_a ^ res_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      start_sweep = 1'b0;
      check_en    = 1'b0;
      timer_load  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && abort) begin
               state_n = IDLE;
            end else if (start) begin
               start_sweep = 1'b1;
               timer_load  = 1'b1;
               state_n     = AFTER_LOAD;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_n = IDLE;
            end else if (expired) begin
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (abort) begin
               state_n = IDLE;
            end else begin
               check_en = 1'b1;
               if (x_out != LAST_VEC) begin
                  timer_load = 1'b1;
                  state_n    = AFTER_LOAD;
               end else begin
                  state_n = DONE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Vector register and result accumulation. On abort none of these are
   // touched, so partial results remain visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_out            <= '0;
         mismatch_cnt     <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (start_sweep) begin
         x_out            <= '0;
         mismatch_cnt     <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (check_en) begin
         if (mismatch) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (!first_fail_valid) begin
               first_fail_vec   <= x_out;
               first_fail_valid <= 1'b1;
            end
         end
         // The last vector ends the sweep; x_out never wraps.
         if (x_out != LAST_VEC) begin
            x_out <= x_out + N_IN'(1);
         end
      end
   end

   assign busy      = (state == SETTLE) || (state == CHECK);
   assign done      = (state == DONE);
   assign pass      = done && (mismatch_cnt == '0);
   assign fsm_state = state;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// -----------------------------------------------------------------------------
// tb_equiv_check_sequencer
//   dut_a: N_IN=2, SETTLE_CYC=1, driven by a NAND-built NOR (res_a) and an
//          expression-form NOR (res_b) with selectable fault injection.
//   dut_b: N_IN=2, SETTLE_CYC=0, implementations that always differ.
// -----------------------------------------------------------------------------
module tb_equiv_check_sequencer;
   import equiv_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- dut_a ----------------
   logic       start_a, abort_a, res_a_a, res_b_a;
   logic [1:0] x_a, ffv_a;
   logic [2:0] cnt_a;
   logic       busy_a, done_a, pass_a, ffvalid_a;
   state_t     st_a;
   int         mode_a;

   equiv_check_sequencer #(.N_IN(2), .SETTLE_CYC(1)) dut_a (
      .clk (clk), .reset (reset), .start (start_a), .abort (abort_a),
      .res_a (res_a_a), .res_b (res_b_a), .x_out (x_a), .busy (busy_a),
      .done (done_a), .pass (pass_a), .mismatch_cnt (cnt_a),
      .first_fail_vec (ffv_a), .first_fail_valid (ffvalid_a), .fsm_state (st_a)
   );

   // ---------------- dut_b ----------------
   logic       start_b, abort_b, res_a_b, res_b_b;
   logic [1:0] x_b, ffv_b;
   logic [2:0] cnt_b;
   logic       busy_b, done_b, pass_b, ffvalid_b;
   state_t     st_b;

   equiv_check_sequencer #(.N_IN(2), .SETTLE_CYC(0)) dut_b (
      .clk (clk), .reset (reset), .start (start_b), .abort (abort_b),
      .res_a (res_a_b), .res_b (res_b_b), .x_out (x_b), .busy (busy_b),
      .done (done_b), .pass (pass_b), .mismatch_cnt (cnt_b),
      .first_fail_vec (ffv_b), .first_fail_valid (ffvalid_b), .fsm_state (st_b)
   );

   // ---------------- implementations under test ----------------
   function automatic logic nand2(input logic p, input logic q);
      return ~(p & q);
   endfunction

   function automatic logic nor_gates(input logic [1:0] v);
      logic or_v;
      or_v = nand2(nand2(v[1], v[1]), nand2(v[0], v[0]));
      return nand2(or_v, or_v);
   endfunction

   // mode 0: equivalent, 1: differ at x==2, 2: always differ, 3: differ at odd x
   always_comb begin
      logic flip;
      flip = (mode_a == 2) || (mode_a == 1 && x_a == 2'd2) || (mode_a == 3 && x_a[0]);
      res_a_a = nor_gates(x_a);
      res_b_a = (~x_a[1] & ~x_a[0]) ^ flip;
   end

   assign res_a_b = nor_gates(x_b);
   assign res_b_b = ~(~x_b[1] & ~x_b[0]);

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Pulse start for one edge, then check the state right after acceptance.
   task automatic start_sweep_a(input int mode);
      @(negedge clk);
      mode_a  = mode;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("accept_busy", busy_a, 1);
      chk("accept_x", x_a, 0);
      chk("accept_done", done_a, 0);
   endtask

   // Follows dut_a after the accepting edge: after edge k, x_out = min(k/2, 3).
   task automatic track_a(output int lat);
      logic [31:0] exp_x;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         exp_x = ((k / 2) > 3) ? 3 : (k / 2);
         chk("sweep_x", x_a, exp_x);
         if (done_a) begin
            lat = k;
            break;
         end
         chk("sweep_busy", busy_a, 1);
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_a: done never rose within 40 edges");
      end
   endtask

   task automatic check_result_a(input string tag, input int lat, input logic [31:0] c,
                                 input logic [31:0] fv, input logic [31:0] fval, input logic [31:0] p);
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_cnt"}, cnt_a, c);
      chk({tag, "_ffvec"}, ffv_a, fv);
      chk({tag, "_ffvalid"}, ffvalid_a, fval);
      chk({tag, "_pass"}, pass_a, p);
      chk({tag, "_done"}, done_a, 1);
      chk({tag, "_busy"}, busy_a, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          mode;
      logic [31:0] cnt;
      logic [31:0] ffv;
      logic [31:0] ffvalid;
      logic [31:0] pass_e;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int lat;

      tbl[0] = '{mode: 0, cnt: 0, ffv: 0, ffvalid: 0, pass_e: 1};
      tbl[1] = '{mode: 1, cnt: 1, ffv: 2, ffvalid: 1, pass_e: 0};
      tbl[2] = '{mode: 2, cnt: 4, ffv: 0, ffvalid: 1, pass_e: 0};
      tbl[3] = '{mode: 3, cnt: 2, ffv: 1, ffvalid: 1, pass_e: 0};

      reset   = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; mode_a = 0;
      start_b = 1'b0; abort_b = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_x", x_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_pass", pass_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_ffvalid", ffvalid_a, 0);
      chk("rst_state", st_a, IDLE);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven sweeps on dut_a
      for (int i = 0; i < 4; i++) begin
         start_sweep_a(tbl[i].mode);
         track_a(lat);
         check_result_a($sformatf("tbl%0d", i), lat, tbl[i].cnt, tbl[i].ffv,
                        tbl[i].ffvalid, tbl[i].pass_e);
         // done is held while idle in DONE
         repeat (3) @(negedge clk);
         chk("done_hold", done_a, 1);
      end

      // abort + start together in DONE: abort wins, back to IDLE
      @(negedge clk);
      start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0;
      chk("abs_state", st_a, IDLE);
      chk("abs_done", done_a, 0);
      chk("abs_busy", busy_a, 0);

      // Abort sampled at edge 5 of an always-differ sweep
      start_sweep_a(2);
      repeat (4) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_state", st_a, IDLE);
      chk("abort_busy", busy_a, 0);
      chk("abort_done", done_a, 0);
      chk("abort_pass", pass_a, 0);
      chk("abort_x", x_a, 2);
      chk("abort_cnt", cnt_a, 2);
      chk("abort_ffvalid", ffvalid_a, 1);
      chk("abort_ffvec", ffv_a, 0);

      // Restart clears partial results and reproduces the equivalent-pair result
      start_sweep_a(0);
      chk("restart_cnt", cnt_a, 0);
      chk("restart_ffvalid", ffvalid_a, 0);
      track_a(lat);
      check_result_a("restart", lat, 0, 0, 0, 1);

      // Async reset mid-SETTLE
      start_sweep_a(0);
      repeat (2) @(negedge clk);
      chk("pre_rst_state", st_a, SETTLE);
      chk("pre_rst_x", x_a, 1);
      #1 reset = 1'b1;
      #1;
      chk("midrst_state", st_a, IDLE);
      chk("midrst_x", x_a, 0);
      chk("midrst_busy", busy_a, 0);
      chk("midrst_cnt", cnt_a, 0);
      @(negedge clk);
      reset = 1'b0;

      // start held high through DONE: back-to-back identical sweeps
      @(negedge clk);
      mode_a  = 1;
      start_a = 1'b1;
      @(negedge clk);
      chk("b2b0_busy", busy_a, 1);
      track_a(lat);
      check_result_a("b2b0", lat, 1, 2, 1, 0);
      @(negedge clk);
      chk("b2b1_done", done_a, 0);
      chk("b2b1_busy", busy_a, 1);
      chk("b2b1_x", x_a, 0);
      chk("b2b1_cnt", cnt_a, 0);
      track_a(lat);
      start_a = 1'b0;
      check_result_a("b2b1", lat, 1, 2, 1, 0);

      // dut_b: SETTLE_CYC=0, always differing; after edge k, x_out = min(k,3)
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_accept_state", st_b, CHECK);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk("b_x", x_b, (k > 3) ? 3 : k);
         if (done_b) begin
            lat = k;
            break;
         end
      end
      chk("b_latency", lat, 4);
      chk("b_cnt", cnt_b, 3'b100);
      chk("b_ffvec", ffv_b, 0);
      chk("b_ffvalid", ffvalid_b, 1);
      chk("b_pass", pass_b, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
